// File: rtl/owner_cashout.sv
// Owner cash-collection controller: holds the machine balance, takes sale
// deposits and pays the owner out one coin unit per cycle.
`timescale 1ns/1ps
module owner_cashout #(
  parameter int W           = 11,
  parameter int FLOAT       = 100,
  parameter int UNIT        = 4,
  parameter int LOCK_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic         deposit_valid,
  input  logic [W-1:0] deposit_amt,
  input  logic         req_valid,
  input  logic [W-1:0] req_amt,
  input  logic         req_all,
  output logic [W-1:0] machine_money,
  output logic [W-1:0] owner_money,
  output logic         pay_pulse,
  output logic         busy,
  output logic         done,
  output logic         abort,
  output logic         redlight
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PAY,
    S_DONE,
    S_LOCK
  } state_t;

  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [W-1:0]  FLT  = W'(FLOAT);
  localparam logic [W-1:0]  UNT  = W'(UNIT);
  localparam logic [W-1:0]  UMSK = W'(UNIT - 1);
  localparam logic [W-1:0]  MAXV = '1;
  localparam logic [LW-1:0] LINI = LW'(LOCK_CYCLES - 1);

  state_t        state;
  state_t        nstate;
  logic [W-1:0]  rem;
  logic [W-1:0]  amt_q;
  logic          all_q;
  logic [LW-1:0] lock_cnt;
  logic          abort_q;

  logic [W-1:0]  avail;
  logic [W-1:0]  amt;
  logic          amt_ok;
  logic          last_unit;
  logic          dep_ok;
  logic [W:0]    dep_sum;
  logic [W-1:0]  mm_base;
  logic [W-1:0]  mm_nxt;
  logic          in_pay;
  logic          take_req;

  assign avail = (machine_money > FLT)
               ? machine_money - FLT : '0;

  // take-all rounds the available money down to whole coins
  assign amt = all_q ? (avail & ~UMSK) : amt_q;

  assign amt_ok = (amt != '0)
               && (amt <= avail)
               && ((amt & UMSK) == '0);

  assign last_unit = (rem == UNT);
  assign in_pay    = (state == S_PAY);
  assign take_req  = (state == S_IDLE)
                  && req_valid && mode;

  assign dep_ok  = deposit_valid && !mode;
  assign dep_sum = {1'b0, machine_money}
                 + {1'b0, deposit_amt};

  always_comb begin
    mm_base = machine_money;
    unique case (1'b1)
      dep_ok && dep_sum[W]:  mm_base = MAXV;
      dep_ok && !dep_sum[W]: mm_base = dep_sum[W-1:0];
      default:               mm_base = machine_money;
    endcase
  end

  assign mm_nxt = in_pay ? mm_base - UNT : mm_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: begin
        if (take_req) nstate = S_CHECK;
      end
      S_CHECK: begin
        nstate = amt_ok ? S_PAY : S_LOCK;
      end
      S_PAY: begin
        if (last_unit) nstate = S_DONE;
        else if (!mode) nstate = S_IDLE;
      end
      S_DONE: begin
        nstate = S_IDLE;
      end
      S_LOCK: begin
        if (lock_cnt == '0) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    pay_pulse = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    redlight  = 1'b0;
    abort     = abort_q;
    unique case (state)
      S_CHECK: busy = 1'b1;
      S_PAY: begin
        busy      = 1'b1;
        pay_pulse = 1'b1;
      end
      S_DONE:  done     = 1'b1;
      S_LOCK:  redlight = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      machine_money <= '0;
      owner_money   <= '0;
    end else begin
      machine_money <= mm_nxt;
      if (in_pay) owner_money <= owner_money + UNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amt_q <= '0;
      all_q <= 1'b0;
    end else if (take_req) begin
      amt_q <= req_amt;
      all_q <= req_all;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
    end else if (state == S_CHECK && amt_ok) begin
      rem <= amt;
    end else if (in_pay) begin
      rem <= rem - UNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if (state == S_CHECK && !amt_ok) begin
      lock_cnt <= LINI;
    end else if (state == S_LOCK && lock_cnt != '0) begin
      lock_cnt <= lock_cnt - 1'b1;
    end
  end

  // a finished last unit counts as completion, not as an abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= in_pay && !mode && !last_unit;
    end
  end

endmodule

// File: tb/tb_owner_cashout.sv
// Directed scoreboard bench for owner_cashout.
`timescale 1ns/1ps
module tb_owner_cashout;

  localparam int W  = 11;
  localparam int FL = 100;
  localparam int UN = 4;
  localparam int LC = 4;
  localparam int MX = 2047;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mode = 1'b0;
  logic         deposit_valid = 1'b0;
  logic [W-1:0] deposit_amt = '0;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_amt = '0;
  logic         req_all = 1'b0;
  logic [W-1:0] machine_money;
  logic [W-1:0] owner_money;
  logic         pay_pulse;
  logic         busy;
  logic         done;
  logic         abort;
  logic         redlight;

  owner_cashout #(
    .W(W), .FLOAT(FL), .UNIT(UN), .LOCK_CYCLES(LC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .deposit_valid(deposit_valid),
    .deposit_amt(deposit_amt),
    .req_valid(req_valid),
    .req_amt(req_amt),
    .req_all(req_all),
    .machine_money(machine_money),
    .owner_money(owner_money),
    .pay_pulse(pay_pulse),
    .busy(busy),
    .done(done),
    .abort(abort),
    .redlight(redlight)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;
  int mm_m = 0;
  int om_m = 0;
  int o_np, o_first, o_last, o_dn;
  int o_red, o_redf, o_ab, o_abc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic void push(string tag, int v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endfunction

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL sb_empty: observed %0d expected none", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".mm"}, machine_money, 0);
    chk({tag, ".om"}, owner_money, 0);
    chk({tag, ".pay"}, pay_pulse, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".abort"}, abort, 0);
    chk({tag, ".red"}, redlight, 0);
  endtask

  task automatic deposit(input string tag, input int amt);
    mm_m = (mm_m + amt > MX) ? MX : mm_m + amt;
    push(tag, mm_m);
    mode = 1'b0;
    deposit_valid = 1'b1;
    deposit_amt = W'(amt);
    tick();
    deposit_valid = 1'b0;
    pop_chk(machine_money);
  endtask

  task automatic expect_req(input string lb,
                            input int amt,
                            input bit all);
    int av;
    int a;
    int n;
    av = (mm_m > FL) ? mm_m - FL : 0;
    a = all ? (av / UN) * UN : amt;
    if (a == 0 || a > av || (a % UN) != 0) begin
      push({lb, ".np"}, 0);
      push({lb, ".first"}, -1);
      push({lb, ".last"}, -1);
      push({lb, ".done"}, -1);
      push({lb, ".red"}, LC);
      push({lb, ".redf"}, 2);
    end else begin
      n = a / UN;
      push({lb, ".np"}, n);
      push({lb, ".first"}, 2);
      push({lb, ".last"}, n + 1);
      push({lb, ".done"}, n + 2);
      push({lb, ".red"}, 0);
      push({lb, ".redf"}, -1);
      mm_m = mm_m - a;
      om_m = (om_m + a) % (MX + 1);
    end
    push({lb, ".mm"}, mm_m);
    push({lb, ".om"}, om_m);
  endtask

  task automatic observe(input int c);
    if (pay_pulse) begin
      o_np++;
      if (o_first < 0) o_first = c;
      o_last = c;
    end
    if (done) o_dn = c;
    if (redlight) begin
      o_red++;
      if (o_redf < 0) o_redf = c;
    end
    if (abort) begin
      o_ab++;
      o_abc = c;
    end
  endtask

  task automatic clear_obs();
    o_np = 0; o_first = -1; o_last = -1; o_dn = -1;
    o_red = 0; o_redf = -1; o_ab = 0; o_abc = -1;
  endtask

  task automatic run_req(input string lb,
                         input int amt,
                         input bit all,
                         input int window);
    expect_req(lb, amt, all);
    mode = 1'b1;
    req_valid = 1'b1;
    req_amt = W'(amt);
    req_all = all;
    tick();
    req_valid = 1'b0;
    req_all = 1'b0;
    chk({lb, ".busy1"}, busy, 1);
    clear_obs();
    for (int c = 1; c <= window; c++) begin
      observe(c);
      tick();
    end
    pop_chk(o_np);
    pop_chk(o_first);
    pop_chk(o_last);
    pop_chk(o_dn);
    pop_chk(o_red);
    pop_chk(o_redf);
    pop_chk(machine_money);
    pop_chk(owner_money);
  endtask

  initial begin
    mode = 1'b0;
    deposit_valid = 1'b1;
    deposit_amt = 11'd500;
    tick();
    tick();
    chk_idle_outs("reset");
    deposit_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // two back-to-back deposits
    mode = 1'b0;
    deposit_valid = 1'b1;
    deposit_amt = 11'd500;
    push("dep500", 500);
    push("dep800", 800);
    tick();
    deposit_amt = 11'd300;
    pop_chk(machine_money);
    tick();
    deposit_valid = 1'b0;
    pop_chk(machine_money);
    mm_m = 800;
    deposit("dep_sat", 2000);

    rst_n = 1'b0;
    #1;
    chk_idle_outs("reset2");
    tick();
    rst_n = 1'b1;
    mm_m = 0;
    om_m = 0;
    deposit("refill_a", 500);
    deposit("refill_b", 300);

    run_req("partial40", 40, 1'b0, 16);
    deposit("top_up40", 40);
    run_req("rej704", 704, 1'b0, 12);
    run_req("rej42", 42, 1'b0, 12);
    run_req("rej0", 0, 1'b0, 12);

    deposit("plus3", 3);
    run_req("take_all", 8, 1'b1, 182);
    run_req("take_all2", 0, 1'b1, 12);
    deposit("back800", 697);

    // abort: mode falls during the third pulse
    push("abort.np", 3);
    push("abort.cnt", 1);
    push("abort.cyc", 5);
    push("abort.done", -1);
    mm_m = mm_m - 3 * UN;
    om_m = om_m + 3 * UN;
    push("abort.mm", mm_m);
    push("abort.om", om_m);
    mode = 1'b1;
    req_valid = 1'b1;
    req_amt = 11'd40;
    tick();
    req_valid = 1'b0;
    clear_obs();
    for (int c = 1; c <= 14; c++) begin
      if (c == 4) mode = 1'b0;
      observe(c);
      tick();
    end
    pop_chk(o_np);
    pop_chk(o_ab);
    pop_chk(o_abc);
    pop_chk(o_dn);
    pop_chk(machine_money);
    pop_chk(owner_money);

    // request in sales mode is ignored
    mode = 1'b0;
    req_valid = 1'b1;
    req_amt = 11'd40;
    clear_obs();
    for (int c = 1; c <= 6; c++) begin
      if (busy) o_red++;
      observe(c);
      tick();
    end
    req_valid = 1'b0;
    chk("salesreq.busy", o_red, 0);
    chk("salesreq.np", o_np, 0);

    // deposit in owner mode is ignored
    push("ownerdep.mm", mm_m);
    mode = 1'b1;
    deposit_valid = 1'b1;
    deposit_amt = 11'd50;
    tick();
    deposit_valid = 1'b0;
    tick();
    pop_chk(machine_money);

    // request arriving during lock is dropped
    push("lockreq.np", 0);
    push("lockreq.red", LC);
    push("lockreq.mm", mm_m);
    push("lockreq.om", om_m);
    mode = 1'b1;
    req_valid = 1'b1;
    req_amt = 11'd42;
    tick();
    req_valid = 1'b0;
    clear_obs();
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin
        req_valid = 1'b1;
        req_amt = 11'd40;
        deposit_valid = 1'b1;
        deposit_amt = 11'd50;
      end
      if (c == 4) begin
        req_valid = 1'b0;
        deposit_valid = 1'b0;
      end
      observe(c);
      tick();
    end
    pop_chk(o_np);
    pop_chk(o_red);
    pop_chk(machine_money);
    pop_chk(owner_money);

    // reset in the fifth pulse cycle
    mode = 1'b1;
    req_valid = 1'b1;
    req_amt = 11'd40;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    chk("midpay.pulse5", pay_pulse, 1);
    rst_n = 1'b0;
    #1;
    chk_idle_outs("midpay.rst");
    tick();
    tick();
    rst_n = 1'b1;
    clear_obs();
    for (int c = 1; c <= 20; c++) begin
      observe(c);
      tick();
    end
    chk("midpay.np", o_np, 0);
    chk("midpay.done", o_dn, -1);
    chk("midpay.mm", machine_money, 0);
    chk("midpay.sb_left", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/owner_cashout.md
# owner_cashout

Parametrised owner-collection controller for the vending machine. It holds the machine's cash balance and accepts sale deposits in sales mode. In owner mode it pays out a requested amount, or everything above a reserved change float, one coin unit per cycle. Invalid requests are refused with a timed red light. It extends the single-shot owner withdrawal with configurable width, change float, coin unit, partial and "take all" withdrawals, abort and saturation handling.

## Interface
- `W`, 11: width of all money quantities.
- `FLOAT`, 100: reserve always left in the machine for change; must be < 2^W.
- `UNIT`, 4: value of one payout coin; must be a power of two, ≥1.
- `LOCK_CYCLES`, 4: cycles `redlight` stays high after a rejected request; ≥1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = sales mode, 1 = owner mode.
- `deposit_valid`  in  1  one-cycle strobe: a sale's money is added to the balance.
- `deposit_amt`  in  W  amount for `deposit_valid`.
- `req_valid`  in  1  one-cycle owner withdrawal request strobe.
- `req_amt`  in  W  requested amount; ignored when `req_all`=1.
- `req_all`  in  1  with `req_valid`: withdraw all available money, rounded down to UNIT.
- `machine_money`  out  W  current balance (registered).
- `owner_money`  out  W  cumulative amount paid to owner, wraps modulo 2^W.
- `pay_pulse`  out  1  high for one cycle per UNIT dispensed.
- `busy`  out  1  high in CHECK and PAY.
- `done`  out  1  one-cycle pulse when a withdrawal completes fully.
- `abort`  out  1  one-cycle pulse when a payout is cut short by `mode` falling.
- `redlight`  out  1  request rejected; held LOCK_CYCLES cycles.

## Operation
- **Reset** (`rst_n`=0, any state, including mid-PAY): state IDLE. Reset also clears `machine_money`, `owner_money`, the remaining-amount register and the lock counter to 0, and drives all outputs to 0. Any payout in progress is discarded.
- **Available money**: `avail` = `machine_money` − FLOAT if `machine_money` > FLOAT, else 0.
- **Deposits**
  - Accepted only when `mode`=0, in any state.
  - `machine_money` ← min(`machine_money` + `deposit_amt`, 2^W−1). Saturate; never wrap.
  - Deposits with `mode`=1 are ignored.
- **States**: IDLE, CHECK, PAY, DONE, LOCK.
- **IDLE**
  - Goes to CHECK on `req_valid`=1 with `mode`=1, latching `req_amt` and `req_all`.
  - `req_valid` with `mode`=0, or in any non-IDLE state, is ignored.
- **CHECK** (one cycle) computes the target amount `amt`:
  - `amt` = `avail` with low log2(UNIT) bits cleared if `req_all`, else the latched `req_amt`.
  - Reject if `amt`=0, `amt` > `avail`, or `amt` is not a multiple of UNIT. On reject, go to LOCK.
  - Otherwise load `remaining` ← `amt` and go to PAY.
- **PAY**
  - Each cycle: `pay_pulse`=1; at the closing edge `machine_money` −= UNIT, `owner_money` += UNIT, `remaining` −= UNIT.
  - When `remaining` reaches UNIT, the last pulse is issued, then go to DONE.
  - If `mode`=0 is sampled in PAY, the current cycle's pulse still completes, then go to IDLE with `abort`=1 for one cycle. Already-paid units stay paid.
- **DONE**: `done`=1 for one cycle, then IDLE.
- **LOCK**: `redlight`=1 for exactly LOCK_CYCLES cycles, then IDLE. Requests arriving during LOCK are dropped.
- **Balance integrity**: `machine_money` never drops below FLOAT because of a payout.

## Timing
- Request sampled at edge 0: CHECK during cycle 1.
- Accepted request of n units: `pay_pulse` high in cycles 2..n+1. `machine_money` and `owner_money` update one cycle after each pulse. `done` is high in cycle n+2; IDLE in cycle n+3.
- Rejected request: `redlight` high in cycles 2..LOCK_CYCLES+1; IDLE in the following cycle.
- Deposit strobe at edge k: new `machine_money` visible from cycle k+1. Back-to-back deposits accumulate every cycle.
- `busy` is high in CHECK and all PAY cycles.

## Test plan
- Reset and deposits: hold `rst_n`=0. All outputs must be 0. Release, then with `mode`=0 deposit 500 then 300 on consecutive cycles → `machine_money`=800 two cycles later. Then deposit 2000 → `machine_money`=2047, saturated.
- Partial withdrawal: balance 800, `mode`=1, `req_amt`=40. Required: 10 `pay_pulse` cycles (cycles 2–11), `done` in cycle 12, `machine_money`=760, `owner_money`=40.
- Rejects: balance 800, request 704 (over `avail`=700), then request 42 (not a multiple of UNIT), then request 0. Each must give `redlight` for exactly 4 cycles, no `pay_pulse`, and an unchanged balance.
- Take all: balance 803, `req_all`=1 → 700 paid in 175 pulses, `machine_money`=103, `done` pulse. Repeat immediately: `avail`=3 rounds down to 0, so the request is rejected with `redlight`.
- Abort and lockout: during a 40 request, drop `mode` after the 3rd pulse → `abort` pulse, `machine_money` reduced by exactly 12, state IDLE. Deposits and `req_valid` issued with the wrong mode or during LOCK have no effect.
- Reset mid-PAY: assert `rst_n` low in the 5th pulse cycle → all outputs 0 immediately. After release, no further `pay_pulse` or `done` appears.
